// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI access arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

    localparam int SPI_FRAME_BITS   = 16;
    localparam int SPI_RX_BITS      = 8;
    localparam int FRAME_CYCLES_DEF = 50;
    localparam int GAP_CYCLES_DEF   = 8;

endpackage

// File: rtl/spi_access_arbiter.sv
// Shares one SPI master engine between two requesters: arbitrate, run one frame,
// capture the read byte, enforce a CS-high gap. SPI_ARB_FIXED_PRIO_EN selects fixed priority.
module spi_access_arbiter
    import spi_arb_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int CNT_W        = 8
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_req0,
    input  logic [SPI_FRAME_BITS-1:0] I_cmd0,
    output logic                      O_done0,
    input  logic                      I_req1,
    input  logic [SPI_FRAME_BITS-1:0] I_cmd1,
    output logic                      O_done1,
    output logic [SPI_RX_BITS-1:0]    O_rdata,
    output logic                      O_busy,
    output logic                      O_spi_tx_en,
    output logic [SPI_FRAME_BITS-1:0] O_spi_data,
    input  logic [SPI_RX_BITS-1:0]    I_spi_rdata
);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    arb_state_t                state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      win, win_nxt;
    logic                      tx_en_nxt, busy_nxt;
    logic                      done0_nxt, done1_nxt;
    logic [SPI_FRAME_BITS-1:0] data_nxt;
    logic [SPI_RX_BITS-1:0]    rdata_nxt;
    logic                      gnt1;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign gnt1 = I_req1 & ~I_req0;
`else
    // last holds the previous winner; on contention the other requester wins
    logic last, last_nxt;
    assign gnt1 = I_req1 & (~I_req0 | ~last);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        win_nxt   = win;
        tx_en_nxt = O_spi_tx_en;
        busy_nxt  = O_busy;
        data_nxt  = O_spi_data;
        rdata_nxt = O_rdata;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
        last_nxt  = last;
`endif
        case (state)
            IDLE: begin
                if (I_req0 | I_req1) begin
                    data_nxt  = gnt1 ? I_cmd1 : I_cmd0;
                    win_nxt   = gnt1;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    last_nxt  = gnt1;
`endif
                    busy_nxt  = 1'b1;
                    tx_en_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (cnt == FRAME_LAST) begin
                    tx_en_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                // engine output is still valid for this one cycle after enable drops
                rdata_nxt = I_spi_rdata;
                done0_nxt = ~win;
                done1_nxt = win;
                cnt_nxt   = '0;
                state_nxt = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            win         <= 1'b0;
            O_spi_tx_en <= 1'b0;
            O_busy      <= 1'b0;
            O_spi_data  <= '0;
            O_rdata     <= '0;
            O_done0     <= 1'b0;
            O_done1     <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last        <= 1'b1;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            win         <= win_nxt;
            O_spi_tx_en <= tx_en_nxt;
            O_busy      <= busy_nxt;
            O_spi_data  <= data_nxt;
            O_rdata     <= rdata_nxt;
            O_done0     <= done0_nxt;
            O_done1     <= done1_nxt;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last        <= last_nxt;
`endif
        end
    end

endmodule
